// File: rtl/pipeline_check_monitor.sv
// pipeline_check_monitor
// Self-check monitor that sits beside the ARMv8 Pipeline. It walks NUM_CHK
// checkpoints: each one fires when FetchedPC reaches its threshold, waits
// SETTLE cycles for the result to reach writeback, then compares dMemOut with
// the expected value. Passes and fails are counted, and a watchdog ends a hung
// run with a sticky timeout.
// Build option: define CHECK_CAPTURE_EN to add first-failure capture outputs
// (fail_got, fail_exp, fail_idx, fail_vld).
module pipeline_check_monitor #(
  parameter int DATA_W  = 64,
  parameter int PC_W    = 64,
  parameter int NUM_CHK = 2,
  parameter int SETTLE  = 4,
  parameter int WDOG_W  = 16,
  parameter int CNT_W   = 8
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        start,
  input  logic [PC_W-1:0]             FetchedPC,
  input  logic [DATA_W-1:0]           dMemOut,
  input  logic [NUM_CHK*PC_W-1:0]     chk_pc,
  input  logic [NUM_CHK*DATA_W-1:0]   chk_exp,
  output logic                        busy,
  output logic                        done,
  output logic                        all_passed,
  output logic                        timeout,
  output logic                        chk_valid,
  output logic                        chk_pass,
  output logic [$clog2(NUM_CHK):0]    chk_idx,
`ifdef CHECK_CAPTURE_EN
  output logic [DATA_W-1:0]           fail_got,
  output logic [DATA_W-1:0]           fail_exp,
  output logic [$clog2(NUM_CHK):0]    fail_idx,
  output logic                        fail_vld,
`endif
  output logic [CNT_W-1:0]            pass_cnt,
  output logic [CNT_W-1:0]            fail_cnt
);

  localparam int IDX_W = $clog2(NUM_CHK) + 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_CHK - 1);
  localparam logic [CNT_W-1:0]  CNT_ALL     = CNT_W'(NUM_CHK);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PC,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE,
    ST_TIMEOUT
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [SET_W-1:0]  settleCnt;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdogNext;
  logic [PC_W-1:0]   curThr;
  logic [DATA_W-1:0] curExp;
  logic              pcHit;
  logic              dataMatch;
  logic              lastIdx;
  logic              wdogExpire;

  // FSM strobes consumed by the datapath registers
  logic startRun;
  logic wdogInc;
  logic settleClr;
  logic settleInc;
  logic doCompare;
  logic enterTimeout;

  // Select the threshold and expected value of the active checkpoint
  always_comb begin
    curThr = '0;
    curExp = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      if (chk_idx == IDX_W'(k)) begin
        curThr = chk_pc[k*PC_W +: PC_W];
        curExp = chk_exp[k*DATA_W +: DATA_W];
      end
    end
  end

  assign pcHit      = (FetchedPC >= curThr);
  assign dataMatch  = (dMemOut == curExp);
  assign lastIdx    = (chk_idx == IDX_LAST);
  // The watchdog expires on the edge where it would reach all-ones, so it never wraps.
  assign wdogNext   = wdog + WDOG_W'(1);
  assign wdogExpire = &wdogNext;

  // Next-state and strobe decode; a timeout outranks progress in WAIT_PC/SETTLE
  always_comb begin
    // NOTE: every signal gets its default before the case so no path can infer a latch.
    stateNext    = state;
    startRun     = 1'b0;
    wdogInc      = 1'b0;
    settleClr    = 1'b0;
    settleInc    = 1'b0;
    doCompare    = 1'b0;
    enterTimeout = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          stateNext = ST_WAIT_PC;
          startRun  = 1'b1;
        end
      end
      ST_WAIT_PC: begin
        wdogInc = 1'b1;
        if (wdogExpire) begin
          stateNext    = ST_TIMEOUT;
          enterTimeout = 1'b1;
        end else if (pcHit) begin
          stateNext = ST_SETTLE;
          settleClr = 1'b1;
        end
      end
      ST_SETTLE: begin
        wdogInc = 1'b1;
        if (wdogExpire) begin
          stateNext    = ST_TIMEOUT;
          enterTimeout = 1'b1;
        end else if (settleCnt == SETTLE_LAST) begin
          stateNext = ST_COMPARE;
        end else begin
          settleInc = 1'b1;
        end
      end
      ST_COMPARE: begin
        // Always completes; the watchdog is held here and not checked.
        doCompare = 1'b1;
        stateNext = lastIdx ? ST_DONE : ST_WAIT_PC;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= stateNext;
    end
  end

  // Run bookkeeping: index, counters, watchdog and status flags
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      chk_idx   <= '0;
      settleCnt <= '0;
      wdog      <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
    end else begin
      chk_valid <= 1'b0;

      if (startRun) begin
        chk_idx   <= '0;
        settleCnt <= '0;
        wdog      <= '0;
        pass_cnt  <= '0;
        fail_cnt  <= '0;
        busy      <= 1'b1;
        done      <= 1'b0;
        timeout   <= 1'b0;
        chk_pass  <= 1'b0;
      end

      if (wdogInc) begin
        wdog <= wdogNext;
      end

      if (settleClr) begin
        settleCnt <= '0;
      end else if (settleInc) begin
        settleCnt <= settleCnt + SET_W'(1);
      end

      if (doCompare) begin
        chk_valid <= 1'b1;
        chk_pass  <= dataMatch;
        if (dataMatch) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        end
        if (lastIdx) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          chk_idx <= chk_idx + IDX_W'(1);
        end
      end

      if (enterTimeout) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        busy    <= 1'b0;
      end
    end
  end

  assign all_passed = done && (pass_cnt == CNT_ALL) && !timeout;

`ifdef CHECK_CAPTURE_EN
  // Capture the first mismatching compare of a run; sticky until the next start
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fail_got <= '0;
      fail_exp <= '0;
      fail_idx <= '0;
      fail_vld <= 1'b0;
    end else if (startRun) begin
      fail_got <= '0;
      fail_exp <= '0;
      fail_idx <= '0;
      fail_vld <= 1'b0;
    end else if (doCompare && !dataMatch && !fail_vld) begin
      fail_got <= dMemOut;
      fail_exp <= curExp;
      fail_idx <= chk_idx;
      fail_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_check_monitor.sv
// tb_pipeline_check_monitor
// Drives PC/data stimulus into pipeline_check_monitor, predicts each compare
// result into a scoreboard queue, and checks the pulses, counters, latency,
// watchdog and reset behaviour. A second instance with a 4-bit watchdog covers
// the timeout path. Honours CHECK_CAPTURE_EN for the capture outputs.
`timescale 1ns/1ps
module tb_pipeline_check_monitor;

  localparam int DATA_W   = 64;
  localparam int PC_W     = 64;
  localparam int NUM_CHK  = 2;
  localparam int SETTLE_P = 4;
  localparam int WD_W     = 4;
  localparam int CNT_W    = 8;
  localparam int IDX_W    = $clog2(NUM_CHK) + 1;

  localparam logic [63:0] THR0 = 64'h058;
  localparam logic [63:0] THR1 = 64'h100;
  localparam logic [63:0] EXP0 = 64'hF;
  localparam logic [63:0] EXP1 = 64'h1234_5678_9abc_def0;

  logic                      Clk     = 1'b0;
  logic                      Rst     = 1'b0;
  logic                      start   = 1'b0;
  logic                      startWd = 1'b0;
  logic [PC_W-1:0]           pc      = '0;
  logic [PC_W-1:0]           pcWd    = '0;
  logic [DATA_W-1:0]         dMem    = '0;
  logic [NUM_CHK*PC_W-1:0]   chkPc;
  logic [NUM_CHK*DATA_W-1:0] chkExp;

  logic             busy, done, allPassed, timeoutO, chkValid, chkPass;
  logic [IDX_W-1:0] chkIdx;
  logic [CNT_W-1:0] passCnt, failCnt;

  logic             busyWd, doneWd, allPassedWd, timeoutWd, chkValidWd, chkPassWd;
  logic [IDX_W-1:0] chkIdxWd;
  logic [CNT_W-1:0] passCntWd, failCntWd;

`ifdef CHECK_CAPTURE_EN
  logic [DATA_W-1:0] failGot, failExp, failGotWd, failExpWd;
  logic [IDX_W-1:0]  failIdx, failIdxWd;
  logic              failVld, failVldWd;
`endif

  int nChecks = 0;
  int nFails  = 0;
  bit sbQ[$];

  assign chkPc  = {THR1, THR0};
  assign chkExp = {EXP1, EXP0};

  pipeline_check_monitor #(
    .DATA_W(DATA_W), .PC_W(PC_W), .NUM_CHK(NUM_CHK),
    .SETTLE(SETTLE_P), .WDOG_W(16), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .FetchedPC(pc), .dMemOut(dMem),
    .chk_pc(chkPc), .chk_exp(chkExp),
    .busy(busy), .done(done), .all_passed(allPassed), .timeout(timeoutO),
    .chk_valid(chkValid), .chk_pass(chkPass), .chk_idx(chkIdx),
`ifdef CHECK_CAPTURE_EN
    .fail_got(failGot), .fail_exp(failExp), .fail_idx(failIdx), .fail_vld(failVld),
`endif
    .pass_cnt(passCnt), .fail_cnt(failCnt)
  );

  pipeline_check_monitor #(
    .DATA_W(DATA_W), .PC_W(PC_W), .NUM_CHK(NUM_CHK),
    .SETTLE(SETTLE_P), .WDOG_W(WD_W), .CNT_W(CNT_W)
  ) dutWd (
    .Clk(Clk), .Rst(Rst), .start(startWd), .FetchedPC(pcWd), .dMemOut(dMem),
    .chk_pc(chkPc), .chk_exp(chkExp),
    .busy(busyWd), .done(doneWd), .all_passed(allPassedWd), .timeout(timeoutWd),
    .chk_valid(chkValidWd), .chk_pass(chkPassWd), .chk_idx(chkIdxWd),
`ifdef CHECK_CAPTURE_EN
    .fail_got(failGotWd), .fail_exp(failExpWd), .fail_idx(failIdxWd), .fail_vld(failVldWd),
`endif
    .pass_cnt(passCntWd), .fail_cnt(failCntWd)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every compare pulse must match the oldest prediction
  always @(negedge Clk) begin
    bit expPass;
    if (chkValid === 1'b1) begin
      check("sb_pending", 64'(sbQ.size() != 0), 64'd1);
      if (sbQ.size() != 0) begin
        expPass = sbQ.pop_front();
        check("chk_pass", 64'(chkPass), 64'(expPass));
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count falling edges until a compare pulse shows up, bounded by a budget
  task automatic countToValid(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (chkValid !== 1'b1 && n < budget);
  endtask

  task automatic waitDone(input string tag);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  // Full run: PC ramps 0..0x100 by 4 per cycle, data switches once PC clears 0x90
  task automatic runRamp(input logic [63:0] d0, input logic [63:0] d1,
                         input bit p0, input bit p1, input bit relRst, input string tag);
    int cyc;
    sbQ.push_back(p0);
    sbQ.push_back(p1);
    pc   = '0;
    dMem = d0;
    if (relRst) Rst = 1'b1;
    pulseStart();
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      pc   = (pc + 64'd4 > THR1) ? THR1 : pc + 64'd4;
      dMem = (pc >= 64'h90) ? d1 : d0;
      tick();
      cyc++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    tick();
    check({tag, "_sb_drained"}, 64'(sbQ.size()), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_timeout"}, 64'(timeoutO), 64'd0);
  endtask

  initial begin
    int n;

    // Reset state of both instances
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_all_passed", 64'(allPassed), 64'd0);
    check("rst_cnts", {48'd0, passCnt, failCnt}, 64'd0);
    check("rst_idx", 64'(chkIdx), 64'd0);
    check("rst_wd_flags", {60'd0, busyWd, doneWd, timeoutWd, chkValidWd}, 64'd0);

    // Clean pass, started in the same cycle reset is released
    runRamp(EXP0, EXP1, 1'b1, 1'b1, 1'b1, "pass");
    check("pass_pass_cnt", 64'(passCnt), 64'd2);
    check("pass_fail_cnt", 64'(failCnt), 64'd0);
    check("pass_all_passed", 64'(allPassed), 64'd1);
    check("pass_idx", 64'(chkIdx), 64'(NUM_CHK - 1));

    // Mismatch at checkpoint 0
    runRamp(64'hE, EXP1, 1'b0, 1'b1, 1'b0, "mism");
    check("mism_pass_cnt", 64'(passCnt), 64'd1);
    check("mism_fail_cnt", 64'(failCnt), 64'd1);
    check("mism_all_passed", 64'(allPassed), 64'd0);
`ifdef CHECK_CAPTURE_EN
    check("cap_got", failGot, 64'hE);
    check("cap_exp", failExp, EXP0);
    check("cap_idx", 64'(failIdx), 64'd0);
    check("cap_vld", 64'(failVld), 64'd1);
`endif

    // Latency: qualifying PC sampled on the next rising edge, pulse SETTLE+1 edges later
    sbQ.push_back(1'b1);
    sbQ.push_back(1'b1);
    pc   = '0;
    dMem = EXP0;
    pulseStart();
    repeat (3) tick();
    pc = THR0;
    countToValid(40, n);
    check("lat_ck0_edges", 64'(n), 64'(SETTLE_P + 2));
    dMem = EXP1;
    pc   = THR1;
    waitDone("lat");
    tick();
    check("lat_pass_cnt", 64'(passCnt), 64'd2);
`ifdef CHECK_CAPTURE_EN
    check("lat_cap_cleared", 64'(failVld), 64'd0);
`endif

    // Start while busy is ignored; a PC already past both thresholds fires them back to back
    sbQ.push_back(1'b1);
    sbQ.push_back(1'b1);
    pc   = '0;
    dMem = EXP0;
    pulseStart();
    repeat (2) tick();
    pulseStart();
    tick();
    check("busy_start_busy", 64'(busy), 64'd1);
    check("busy_start_cnts", {48'd0, passCnt, failCnt}, 64'd0);
    check("busy_start_idx", 64'(chkIdx), 64'd0);
    pc = THR1;
    countToValid(40, n);
    check("noskip_ck0_edges", 64'(n), 64'(SETTLE_P + 2));
    dMem = EXP1;
    countToValid(40, n);
    check("noskip_ck1_edges", 64'(n), 64'(SETTLE_P + 2));
    check("noskip_done", 64'(done), 64'd1);
    check("noskip_all_passed", 64'(allPassed), 64'd1);
    tick();
    check("noskip_sb_drained", 64'(sbQ.size()), 64'd0);

    // Reset asserted mid-run, during SETTLE: outputs clear without a clock edge
    sbQ.push_back(1'b1);
    sbQ.push_back(1'b1);
    pc   = '0;
    dMem = EXP0;
    pulseStart();
    tick();
    pc = THR0;
    repeat (3) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 Rst = 1'b0;
    #1;
    check("async_rst_flags", {58'd0, busy, done, allPassed, timeoutO, chkValid, chkPass}, 64'd0);
    check("async_rst_idx", 64'(chkIdx), 64'd0);
    sbQ.delete();
    tick();
    Rst = 1'b1;
    tick();
    runRamp(EXP0, EXP1, 1'b1, 1'b1, 1'b0, "post_rst");
    check("post_rst_pass_cnt", 64'(passCnt), 64'd2);
    check("post_rst_all_passed", 64'(allPassed), 64'd1);

    // Watchdog: PC stuck at 0, timeout after 2^WD_W-1 cycles in WAIT_PC (+1 edge for start)
    startWd = 1'b1;
    tick();
    startWd = 1'b0;
    n = 1;
    while (timeoutWd !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("wdog_edges", 64'(n), 64'((1 << WD_W) - 1 + 1));
    check("wdog_done", 64'(doneWd), 64'd1);
    check("wdog_busy", 64'(busyWd), 64'd0);
    check("wdog_all_passed", 64'(allPassedWd), 64'd0);
    check("wdog_cnts", {48'd0, passCntWd, failCntWd}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
